// File: rtl/pipelined_cla_add_sub_if.sv
// Operand/result handshake bundle for the pipelined CLA adder-subtractor.
// The master side sources operations and sinks results; the slave side is the datapath.
interface pipelined_cla_add_sub_if #(
  parameter int M = 32
);
  logic         in_valid;
  logic         in_ready;
  logic         sub;
  logic         cin;
  logic [M-1:0] x;
  logic [M-1:0] y;
  logic         out_valid;
  logic         out_ready;
  logic [M-1:0] out;
  logic         cout;
  logic         v;
  logic         zero;
  logic         neg;

  modport master (
    output in_valid, sub, cin, x, y, out_ready,
    input  in_ready, out_valid, out, cout, v, zero, neg
  );

  modport slave (
    input  in_valid, sub, cin, x, y, out_ready,
    output in_ready, out_valid, out, cout, v, zero, neg
  );
endinterface

// File: rtl/pipelined_cla_add_sub.sv
// Pipelined add/subtract: one BLK-bit carry-look-ahead segment per stage, with the
// inter-segment carry registered and operands/results skewed so one op completes per cycle.
module pipelined_cla_add_sub #(
  parameter int M   = 32,
  parameter int BLK = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  pipelined_cla_add_sub_if.slave bus
);
  localparam int NSEG = M / BLK;
  localparam int NGRP = BLK / 4;
  localparam int LAST = NSEG - 1;

  if ((BLK < 4) || ((BLK % 4) != 0) || ((M % BLK) != 0)) begin : g_badParams
    $error("pipelined_cla_add_sub: M must be a multiple of BLK and BLK a multiple of 4");
  end

  // Returns {carry out, sum}; group G/P feed a look-ahead across groups, bits inside a group use look-ahead too.
  function automatic logic [BLK:0] claSegment(input logic [BLK-1:0] a, input logic [BLK-1:0] b,
                                              input logic cIn);
    logic [BLK-1:0]  p;
    logic [BLK-1:0]  g;
    logic [BLK-1:0]  c;
    logic [NGRP-1:0] gg;
    logic [NGRP-1:0] gp;
    logic [NGRP:0]   gc;
    logic            term;
    p = a ^ b;
    g = a & b;
    for (int k = 0; k < NGRP; k++) begin
      gp[k] = &p[4*k +: 4];
      gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1]) |
              (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
    end
    for (int k = 0; k <= NGRP; k++) begin
      gc[k] = cIn;
      for (int j = 0; j < k; j++) gc[k] = gc[k] & gp[j];
      for (int j = 0; j < k; j++) begin
        term = gg[j];
        for (int m = j + 1; m < k; m++) term = term & gp[m];
        gc[k] = gc[k] | term;
      end
    end
    for (int k = 0; k < NGRP; k++) begin
      for (int i = 0; i < 4; i++) begin
        c[4*k+i] = gc[k];
        for (int m = 0; m < i; m++) c[4*k+i] = c[4*k+i] & p[4*k+m];
        for (int j = 0; j < i; j++) begin
          term = g[4*k+j];
          for (int m = j + 1; m < i; m++) term = term & p[4*k+m];
          c[4*k+i] = c[4*k+i] | term;
        end
      end
    end
    return {gc[NGRP], p ^ c};
  endfunction

  logic         w_en;
  logic         w_c0;
  logic [M-1:0] w_yn;
  logic [M-1:0] w_out;

  assign w_yn = bus.y ^ {M{bus.sub}};
  assign w_c0 = bus.cin ^ bus.sub;

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    logic [BLK-1:0] w_a;
    logic [BLK-1:0] w_b;
    logic           w_cIn;
    logic           w_prevZero;
    logic           w_prevSub;
    logic           w_prevValid;
    logic [BLK:0]   w_cla;
    logic           r_valid;
    logic           r_carry;
    logic           r_zero;
    logic           r_sub;
    logic [BLK-1:0] r_res [NSEG-k];

    if (k == 0) begin : g_first
      assign w_a         = bus.x[BLK-1:0];
      assign w_b         = w_yn[BLK-1:0];
      assign w_cIn       = w_c0;
      assign w_prevZero  = 1'b1;
      assign w_prevSub   = bus.sub;
      assign w_prevValid = bus.in_valid;
    end else begin : g_skew
      logic [BLK-1:0] r_xDly  [k];
      logic [BLK-1:0] r_ynDly [k];

      // Segment k operands wait k cycles so they meet the carry arriving from stage k-1.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < k; i++) begin
            r_xDly[i]  <= '0;
            r_ynDly[i] <= '0;
          end
        end else if (w_en) begin
          r_xDly[0]  <= bus.x[k*BLK +: BLK];
          r_ynDly[0] <= w_yn[k*BLK +: BLK];
          for (int i = 1; i < k; i++) begin
            r_xDly[i]  <= r_xDly[i-1];
            r_ynDly[i] <= r_ynDly[i-1];
          end
        end
      end

      assign w_a         = r_xDly[k-1];
      assign w_b         = r_ynDly[k-1];
      assign w_cIn       = g_seg[k-1].r_carry;
      assign w_prevZero  = g_seg[k-1].r_zero;
      assign w_prevSub   = g_seg[k-1].r_sub;
      assign w_prevValid = g_seg[k-1].r_valid;
    end

    assign w_cla = claSegment(w_a, w_b, w_cIn);

    // r_res[0] is the stage register; the remaining entries de-skew toward the output.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_valid <= 1'b0;
        r_carry <= 1'b0;
        r_zero  <= 1'b0;
        r_sub   <= 1'b0;
        for (int i = 0; i < NSEG - k; i++) r_res[i] <= '0;
      end else if (w_en) begin
        r_valid  <= w_prevValid;
        r_carry  <= w_cla[BLK];
        r_zero   <= w_prevZero & ~|w_cla[BLK-1:0];
        r_sub    <= w_prevSub;
        r_res[0] <= w_cla[BLK-1:0];
        for (int i = 1; i < NSEG - k; i++) r_res[i] <= r_res[i-1];
      end
    end

    assign w_out[k*BLK +: BLK] = r_res[NSEG-k-1];

    if (k == LAST) begin : g_last
      logic r_carryMsb;

      // The carry into the MSB is recovered from sum ^ a ^ b at the top bit.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_carryMsb <= 1'b0;
        end else if (w_en) begin
          r_carryMsb <= w_cla[BLK-1] ^ w_a[BLK-1] ^ w_b[BLK-1];
        end
      end
    end
  end

  assign w_en          = bus.out_ready | ~g_seg[LAST].r_valid;
  assign bus.in_ready  = w_en;
  assign bus.out_valid = g_seg[LAST].r_valid;
  assign bus.out       = w_out;
  assign bus.cout      = g_seg[LAST].r_carry ^ g_seg[LAST].r_sub;
  assign bus.v         = g_seg[LAST].r_carry ^ g_seg[LAST].g_last.r_carryMsb;
  assign bus.zero      = g_seg[LAST].r_zero;
  assign bus.neg       = w_out[M-1];
endmodule

// File: tb/tb_pipelined_cla_add_sub.sv
// Self-checking bench: table vectors and random streams through a scoreboard on the
// 4-stage instance, plus reset-flush, latency and a single-stage (BLK=M) instance.
module tb_pipelined_cla_add_sub;
  localparam int M = 32;

  typedef struct packed {
    logic [M-1:0] out;
    logic         cout;
    logic         v;
    logic         zero;
    logic         neg;
  } resT;

  typedef struct {
    logic [M-1:0] x;
    logic [M-1:0] y;
    logic         sub;
    logic         cin;
    resT          exp;
  } vecT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipelined_cla_add_sub_if #(.M(M)) bus0 ();
  pipelined_cla_add_sub_if #(.M(M)) bus1 ();

  pipelined_cla_add_sub #(.M(M), .BLK(8))  dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  pipelined_cla_add_sub #(.M(M), .BLK(32)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  int   checkCount = 0;
  int   failCount  = 0;
  resT  expQ[$];
  logic readyMode  = 1'b0;

  function automatic resT refModel(input logic [M-1:0] x, input logic [M-1:0] y,
                                   input logic sub, input logic cin);
    resT          r;
    logic [M-1:0] yn;
    logic         c0;
    logic [M:0]   s;
    logic [M-1:0] low;
    yn     = y ^ {M{sub}};
    c0     = cin ^ sub;
    s      = {1'b0, x} + {1'b0, yn} + {{M{1'b0}}, c0};
    low    = {1'b0, x[M-2:0]} + {1'b0, yn[M-2:0]} + {{(M-1){1'b0}}, c0};
    r.out  = s[M-1:0];
    r.cout = s[M] ^ sub;
    r.v    = low[M-1] ^ s[M];
    r.zero = (s[M-1:0] == '0);
    r.neg  = s[M-1];
    return r;
  endfunction

  function automatic vecT mkVec(input logic [M-1:0] x, input logic [M-1:0] y, input logic sub,
                                input logic cin, input logic [M-1:0] o, input logic co,
                                input logic ov, input logic z, input logic n);
    vecT t;
    t.x   = x;
    t.y   = y;
    t.sub = sub;
    t.cin = cin;
    t.exp = {o, co, ov, z, n};
    return t;
  endfunction

  function automatic resT read0();
    return {bus0.out, bus0.cout, bus0.v, bus0.zero, bus0.neg};
  endfunction

  function automatic resT read1();
    return {bus1.out, bus1.cout, bus1.v, bus1.zero, bus1.neg};
  endfunction

  task automatic checkOutput(input string name, input resT act, input resT exp);
    checkCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got out=%h cout=%b v=%b zero=%b neg=%b, expected out=%h cout=%b v=%b zero=%b neg=%b",
               name, act.out, act.cout, act.v, act.zero, act.neg,
               exp.out, exp.cout, exp.v, exp.zero, exp.neg);
    end
  endtask

  task automatic checkFlag(input string name, input logic act, input logic exp);
    checkCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that accepted the op.
  task automatic applyStimulus(input vecT vec, input logic useTableExp);
    resT  e;
    logic accepted;
    e = useTableExp ? vec.exp : refModel(vec.x, vec.y, vec.sub, vec.cin);
    bus0.x        = vec.x;
    bus0.y        = vec.y;
    bus0.sub      = vec.sub;
    bus0.cin      = vec.cin;
    bus0.in_valid = 1'b1;
    accepted      = 1'b0;
    for (int i = 0; i < 200 && !accepted; i++) begin
      bus0.out_ready = readyMode ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (bus0.in_ready) begin
        expQ.push_back(e);
        accepted = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!accepted) begin
      checkCount++;
      failCount++;
      $display("[TB] FAIL accept_timeout: got in_ready=0 for 200 cycles, expected acceptance");
    end
    bus0.in_valid = 1'b0;
  endtask

  task automatic drain();
    bus0.in_valid  = 1'b0;
    bus0.out_ready = 1'b1;
    for (int i = 0; i < 40 && expQ.size() > 0; i++) begin
      @(posedge clk);
      #1;
    end
    checkCount++;
    if (expQ.size() != 0) begin
      failCount++;
      $display("[TB] FAIL drain: got %0d results outstanding, expected 0", expQ.size());
    end
  endtask

  // Scoreboard and stall-stability monitor for the 4-stage instance.
  initial begin
    resT  prevOut;
    logic prevStall;
    prevStall = 1'b0;
    prevOut   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prevStall = 1'b0;
      end else begin
        if (prevStall) checkOutput("stall_hold", read0(), prevOut);
        if (bus0.out_valid && bus0.out_ready) begin
          if (expQ.size() == 0) begin
            checkCount++;
            failCount++;
            $display("[TB] FAIL unexpected_result: got out=%h, expected no result", bus0.out);
          end else begin
            checkOutput("result", read0(), expQ.pop_front());
          end
        end
        prevStall = bus0.out_valid && !bus0.out_ready;
        prevOut   = read0();
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got simulation time limit, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecT tbl[9];
    vecT v1[3];
    vecT rv;

    bus0.in_valid = 1'b0; bus0.out_ready = 1'b1; bus0.sub = 1'b0; bus0.cin = 1'b0;
    bus0.x = '0; bus0.y = '0;
    bus1.in_valid = 1'b0; bus1.out_ready = 1'b1; bus1.sub = 1'b0; bus1.cin = 1'b0;
    bus1.x = '0; bus1.y = '0;

    tbl[0] = mkVec(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
    tbl[1] = mkVec(32'd5,         32'd7,         1'b1, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 1'b1);
    tbl[2] = mkVec(32'd10,        32'd3,         1'b1, 1'b1, 32'h0000_0006, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[3] = mkVec(32'h7FFF_FFFF, 32'd1,         1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
    tbl[4] = mkVec(32'h8000_0000, 32'd1,         1'b1, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[5] = mkVec(32'h0000_0000, 32'h0,         1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[6] = mkVec(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1);
    tbl[7] = mkVec(32'h0001_0000, 32'd1,         1'b1, 1'b0, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[8] = mkVec(32'h0000_00FF, 32'd1,         1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset_outputs", read0(), '0);
    checkFlag("reset_out_valid", bus0.out_valid, 1'b0);
    checkFlag("reset_in_ready", bus0.in_ready, 1'b1);

    $display("[TB] directed vector table");
    for (int i = 0; i < 9; i++) applyStimulus(tbl[i], 1'b1);
    drain();

    $display("[TB] random stream with toggling out_ready");
    readyMode = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rv = mkVec($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 '0, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(rv, 1'b0);
    end
    readyMode = 1'b0;
    drain();

    $display("[TB] reset discards in-flight operations");
    for (int i = 0; i < 3; i++) begin
      rv = mkVec($urandom, $urandom, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(rv, 1'b0);
    end
    bus0.x        = 32'h1234_5678;
    bus0.in_valid = 1'b1;
    rst           = 1'b1;
    @(posedge clk);
    #1;
    rst           = 1'b0;
    bus0.in_valid = 1'b0;
    expQ.delete();
    checkOutput("flush_outputs", read0(), '0);
    checkFlag("flush_out_valid", bus0.out_valid, 1'b0);
    checkFlag("flush_in_ready", bus0.in_ready, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkFlag("flush_no_result", bus0.out_valid, 1'b0);
    end
    @(posedge clk);
    #1;

    $display("[TB] back-to-back latency, 4 stages");
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          rv = mkVec($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     '0, 1'b0, 1'b0, 1'b0, 1'b0);
          applyStimulus(rv, 1'b0);
        end
      end
      begin
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          checkFlag("latency4_out_valid", bus0.out_valid, (i >= 4) && (i <= 8));
        end
      end
    join
    @(posedge clk);
    #1;
    drain();

    $display("[TB] back-to-back latency, single stage");
    v1[0] = mkVec(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    v1[1] = mkVec(32'd5,         32'd7, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    v1[2] = mkVec(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          bus1.x        = v1[i].x;
          bus1.y        = v1[i].y;
          bus1.sub      = v1[i].sub;
          bus1.cin      = v1[i].cin;
          bus1.in_valid = 1'b1;
          @(posedge clk);
          #1;
        end
        bus1.in_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          checkFlag("latency1_out_valid", bus1.out_valid, (i >= 1) && (i <= 3));
          if (i >= 1 && i <= 3)
            checkOutput("latency1_result", read1(), refModel(v1[i-1].x, v1[i-1].y, v1[i-1].sub, v1[i-1].cin));
        end
      end
    join
    @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end
endmodule
